// File: rtl/led_show_scheduler_if.sv
// Requester-side bundle of the LED show scheduler: request/pattern inputs,
// completion acks, and the status/LED outputs.
interface led_show_scheduler_if #(
    parameter int BITS = 4,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req;
    logic [NREQ*BITS-1:0] pattern;
    logic [NREQ-1:0]      ack;
    logic                 busy;
    logic                 tick;
    logic [BITS-1:0]      led;

    modport master (
        output req, pattern,
        input  ack, busy, tick, led
    );

    modport slave (
        input  req, pattern,
        output ack, busy, tick, led
    );
endinterface

// File: rtl/led_show_scheduler.sv
// Time-shares the LED bank between round-robin requesters and a tick-driven
// idle counter; every output is registered.
module led_show_scheduler #(
    parameter int BITS       = 4,
    parameter int LOG2DELAY  = 22,
    parameter int HOLD_TICKS = 4,
    parameter int NREQ       = 4
) (
    input logic                 clk,
    input logic                 rst,
    led_show_scheduler_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t              state_q, state_d;
    logic [LOG2DELAY-1:0] presc_q, presc_d;
    logic [BITS-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       grant_q, grant_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [BITS-1:0]     pat_q, pat_d;
    logic [BITS-1:0]     led_q, led_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                tick_q, tick_d;

    logic                tick_now;
    logic                found;
    logic [PW-1:0]       win;
    int unsigned         idx;

    assign tick_now = (presc_q == '1);

    // First requester at or after ptr, wrapping at NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_comb begin
        presc_d = presc_q + 1'b1;
        cnt_d   = tick_now ? cnt_q + 1'b1 : cnt_q;
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        hold_d  = hold_q;
        pat_d   = pat_q;
        ack_d   = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = SHOW;
                    grant_d = win;
                    pat_d   = bus.pattern[win*BITS +: BITS];
                    hold_d  = '0;
                end
            end
            SHOW: begin
                if (tick_now) begin
                    if (hold_q == HW'(HOLD_TICKS - 1)) begin
                        state_d        = GAP;
                        ack_d[grant_q] = 1'b1;
                        ptr_d          = (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            GAP: begin
                if (tick_now) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from next-state values so they align with the state.
        case (state_d)
            IDLE:    led_d = cnt_d;
            SHOW:    led_d = pat_d;
            default: led_d = '0;
        endcase
        busy_d = (state_d != IDLE);
        tick_d = (presc_d == '1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            hold_q  <= '0;
            pat_q   <= '0;
            led_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
            pat_q   <= pat_d;
            led_q   <= led_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.led  = led_q;
    assign bus.ack  = ack_q;
    assign bus.busy = busy_q;
    assign bus.tick = tick_q;
endmodule

// File: tb/tb_led_show_scheduler.sv
// Bench for led_show_scheduler: directed scenarios with literal expectations
// plus randomized traffic against a cycle-count based reference model.
module tb_led_show_scheduler;
    localparam int BITS = 4;
    localparam int LOG2DELAY = 2;
    localparam int P = 4;
    localparam int HOLD = 2;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    led_show_scheduler_if #(.BITS(BITS), .NREQ(N)) bus ();

    led_show_scheduler #(
        .BITS(BITS), .LOG2DELAY(LOG2DELAY), .HOLD_TICKS(HOLD), .NREQ(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: k counts cycles since reset; ticks fall where k%P == P-1,
    // so the idle count is simply k/P. A show is a countdown of remaining ticks.
    typedef enum {M_IDLE, M_SHOW, M_GAP} mode_t;
    mode_t           mode = M_IDLE;
    int              k = 0;
    int              rr = 0;
    int              owner = 0;
    int              left = 0;
    logic [BITS-1:0] shown = '0;
    logic [N-1:0]    e_ack = '0;
    logic [BITS-1:0] e_led;

    always @(posedge clk) begin
        if (rst) begin
            k = 0; mode = M_IDLE; rr = 0; e_ack = '0;
        end else begin
            e_ack = '0;
            case (mode)
                M_IDLE: if (bus.req != 0) begin
                    for (int j = N - 1; j >= 0; j--)
                        if (bus.req[(rr + j) % N]) owner = (rr + j) % N;
                    shown = bus.pattern[owner*BITS +: BITS];
                    left  = HOLD;
                    mode  = M_SHOW;
                end
                M_SHOW: if (k % P == P - 1) begin
                    left--;
                    if (left == 0) begin
                        mode  = M_GAP;
                        e_ack = N'(1 << owner);
                        rr    = (owner + 1) % N;
                    end
                end
                M_GAP: if (k % P == P - 1) mode = M_IDLE;
                default: mode = M_IDLE;
            endcase
            k++;
        end
        #1;
        e_led = (mode == M_IDLE) ? BITS'((k / P) % 16) : (mode == M_SHOW) ? shown : '0;
        chk("m_led", 32'(bus.led), 32'(e_led));
        chk("m_ack", 32'(bus.ack), 32'(e_ack));
        chk("m_busy", 32'(bus.busy), 32'(mode != M_IDLE));
        chk("m_tick", 32'(bus.tick), 32'(k % P == P - 1));
    end

    task automatic wait_grant(input string name);
        int c;
        c = 0;
        while (bus.busy && c < 100) begin @(negedge clk); c++; end
        while (!bus.busy && c < 200) begin @(negedge clk); c++; end
        chk({name, "_grant_to"}, 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_ack(input string name);
        int c;
        c = 0;
        while (bus.ack == 0 && c < 100) begin @(negedge clk); c++; end
        chk({name, "_ack_to"}, 32'(bus.ack != 0), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [BITS-1:0] rr_led [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
    logic [N-1:0]    rr_ack [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.pattern = '0;
        repeat (2) @(negedge clk);
        chk("rst_led", 32'(bus.led), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_tick", 32'(bus.tick), 0);
        rst = 1'b0;

        // Idle count wraps after 16 ticks.
        repeat (63) @(negedge clk);
        chk("idle_led15", 32'(bus.led), 32'hF);
        chk("idle_tick", 32'(bus.tick), 1);
        @(negedge clk);
        chk("idle_wrap", 32'(bus.led), 0);

        // Single request.
        bus.req = 4'b0100;
        bus.pattern = 16'h0A00;
        @(negedge clk);
        chk("single_led", 32'(bus.led), 32'hA);
        chk("single_busy", 32'(bus.busy), 1);
        bus.req = '0;
        wait_ack("single");
        chk("single_ack", 32'(bus.ack), 32'b0100);
        chk("single_gap_led", 32'(bus.led), 0);
        @(negedge clk);
        chk("single_ack_off", 32'(bus.ack), 0);
        repeat (8) @(negedge clk);

        // Round robin from a fresh pointer, then pointer skip.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.pattern = 16'h8421;
        bus.req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            wait_grant("rr");
            chk("rr_led", 32'(bus.led), 32'(rr_led[i]));
            wait_ack("rr");
            chk("rr_ack", 32'(bus.ack), 32'(rr_ack[i]));
            if (i < 5) begin
                bus.req = bus.req & ~bus.ack;
                @(negedge clk);
                bus.req = 4'b1111;
            end else begin
                bus.req = 4'b1001;
            end
        end
        wait_grant("skip");
        chk("skip_led3", 32'(bus.led), 32'h8);
        wait_ack("skip");
        chk("skip_ack3", 32'(bus.ack), 32'b1000);
        bus.req = 4'b0001;
        wait_grant("skip");
        chk("skip_led0", 32'(bus.led), 32'h1);
        wait_ack("skip");
        chk("skip_ack0", 32'(bus.ack), 32'b0001);
        bus.req = '0;

        // Drop request and change pattern mid-show.
        wait_grant_idle: repeat (10) @(negedge clk);
        bus.pattern = 16'h0005;
        bus.req = 4'b0001;
        @(negedge clk);
        chk("drop_led_grant", 32'(bus.led), 32'h5);
        bus.req = '0;
        bus.pattern = 16'hFFFF;
        repeat (3) @(negedge clk);
        chk("drop_led_hold", 32'(bus.led), 32'h5);
        wait_ack("drop");
        chk("drop_ack", 32'(bus.ack), 32'b0001);
        repeat (10) @(negedge clk);

        // Asynchronous reset mid-show.
        bus.pattern = 16'h0A00;
        bus.req = 4'b0100;
        @(negedge clk);
        chk("rmid_led", 32'(bus.led), 32'hA);
        #2 rst = 1'b1;
        #1;
        chk("rmid_led0", 32'(bus.led), 0);
        chk("rmid_ack0", 32'(bus.ack), 0);
        chk("rmid_busy0", 32'(bus.busy), 0);
        chk("rmid_tick0", 32'(bus.tick), 0);
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rmid_count", 32'(bus.led), 32'h1);
        bus.pattern = 16'h0030;
        bus.req = 4'b0010;
        @(negedge clk);
        chk("rmid_regrant", 32'(bus.led), 32'h3);
        bus.req = '0;

        // Randomized traffic; requesters drop on ack, occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.ack != 0) bus.req = bus.req & ~bus.ack;
            else if ($urandom_range(0, 7) == 0) bus.req = N'($urandom);
            bus.pattern = 16'($urandom);
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        bus.req = '0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
